// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit byte-strobed registers to the core.
// Define AXI_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_slave_regs #(
  parameter int NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;
`ifdef AXI_SLVERR_EN
  localparam resp_t RESP_OOR = 2'b10;
`else
  localparam resp_t RESP_OOR = 2'b00;
`endif

  // Readies stay low until the first edge after reset release.
  logic             ready_en_q;
  logic             aw_held_q, aw_ok_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic             w_held_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;
  logic             bvalid_q;
  resp_t            bresp_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  resp_t            rresp_q;
  logic [31:0]      regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [31:0]      wr_word_d;

  logic [29:0] aw_word, ar_word;
  logic        aw_in_range, ar_in_range;
  logic        unused_addr_bits;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;

  assign aw_word          = S_AXI_AWADDR[31:2];
  assign ar_word          = S_AXI_ARADDR[31:2];
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign aw_in_range      = aw_word < 30'(NUM_REGS);
  assign ar_in_range      = ar_word < 30'(NUM_REGS);

  assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = ready_en_q && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs   = bvalid_q && S_AXI_BREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs   = rvalid_q && S_AXI_RREADY;
  assign commit = aw_held_q && w_held_q && !bvalid_q;

  always_comb begin
    wr_word_d = regs_q[aw_idx_q];
    for (int b = 0; b < 4; b++) begin
      if (w_strb_q[b]) wr_word_d[8*b +: 8] = w_data_q[8*b +: 8];
    end
  end

  // NOTE: the register array is reset because the core observes reg_q directly
  // and must see zeros after reset; a plain storage RAM would not need this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_ok_q    <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_pulse_q <= '0;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_ok_q   <= aw_in_range;
        aw_idx_q  <= aw_word[IDX_W-1:0];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= aw_ok_q ? RESP_OKAY : RESP_OOR;
        if (aw_ok_q) begin
          regs_q[aw_idx_q]     <= wr_word_d;
          wr_pulse_q[aw_idx_q] <= 1'b1;
        end
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // A read sampled on the commit edge sees the pre-write contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_in_range ? regs_q[ar_word[IDX_W-1:0]] : 32'h0;
      rresp_q  <= ar_in_range ? RESP_OKAY : RESP_OOR;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign wr_pulse     = wr_pulse_q;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi4_lite_slave_regs;
  localparam int NUM_REGS = 16;
`ifdef AXI_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0;
  logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_ARVALID = 0;
  logic [3:0] S_AXI_WSTRB = '0;
  logic S_AXI_BREADY = 1, S_AXI_RREADY = 1;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0] wr_pulse;

  axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_en, m_aw_held, m_w_held, m_bvalid, m_rvalid;
  bit [31:0] m_aw_addr, m_w_data, m_rdata;
  bit [3:0]  m_w_strb;
  bit [1:0]  m_bresp, m_rresp;
  bit [31:0] m_regs [NUM_REGS];
  bit [NUM_REGS-1:0] m_pulse;
  bit [NUM_REGS*32-1:0] exp_flat;
  bit m_awready, m_wready, m_arready, m_aw_hs, m_w_hs, m_ar_hs, m_b_hs, m_r_hs, m_commit;

  function automatic bit in_rng(bit [31:0] a);
    return (a >> 2) < NUM_REGS;
  endfunction

  function automatic bit [31:0] byte_mask(bit [3:0] s);
    bit [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m |= 32'hFF << (8 * b);
    return m;
  endfunction

  assign m_awready = m_en && !m_aw_held && !m_bvalid;
  assign m_wready  = m_en && !m_w_held && !m_bvalid;
  assign m_arready = m_en && !m_rvalid;
  assign m_aw_hs   = S_AXI_AWVALID && m_awready;
  assign m_w_hs    = S_AXI_WVALID && m_wready;
  assign m_ar_hs   = S_AXI_ARVALID && m_arready;
  assign m_b_hs    = m_bvalid && S_AXI_BREADY;
  assign m_r_hs    = m_rvalid && S_AXI_RREADY;
  assign m_commit  = m_aw_held && m_w_held && !m_bvalid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en <= 0; m_aw_held <= 0; m_w_held <= 0; m_bvalid <= 0; m_rvalid <= 0;
      m_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] <= '0;
    end else begin
      m_en <= 1;
      if (m_ar_hs) begin
        m_rvalid <= 1;
        m_rdata  <= in_rng(S_AXI_ARADDR) ? m_regs[S_AXI_ARADDR >> 2] : 32'h0;
        m_rresp  <= in_rng(S_AXI_ARADDR) ? 2'b00 : OOR_RESP;
      end else if (m_r_hs) begin
        m_rvalid <= 0;
      end
      m_pulse <= '0;
      if (m_commit) begin
        m_bvalid <= 1; m_aw_held <= 0; m_w_held <= 0;
        if (in_rng(m_aw_addr)) begin
          m_regs[m_aw_addr >> 2] <= (m_regs[m_aw_addr >> 2] & ~byte_mask(m_w_strb)) |
                                    (m_w_data & byte_mask(m_w_strb));
          m_pulse <= NUM_REGS'(1) << (m_aw_addr >> 2);
          m_bresp <= 2'b00;
        end else begin
          m_bresp <= OOR_RESP;
        end
      end else if (m_b_hs) begin
        m_bvalid <= 0;
      end
      if (m_aw_hs) begin m_aw_held <= 1; m_aw_addr <= S_AXI_AWADDR; end
      if (m_w_hs) begin m_w_held <= 1; m_w_data <= S_AXI_WDATA; m_w_strb <= S_AXI_WSTRB; end
    end
  end

  always_comb begin
    exp_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) exp_flat[32*i +: 32] = m_regs[i];
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("awready", S_AXI_AWREADY, m_awready);
    check("wready", S_AXI_WREADY, m_wready);
    check("arready", S_AXI_ARREADY, m_arready);
    check("bvalid", S_AXI_BVALID, m_bvalid);
    if (m_bvalid) check("bresp", S_AXI_BRESP, m_bresp);
    check("rvalid", S_AXI_RVALID, m_rvalid);
    if (m_rvalid) begin
      check("rdata", S_AXI_RDATA, m_rdata);
      check("rresp", S_AXI_RRESP, m_rresp);
    end
    check("reg_q", reg_q, exp_flat);
    check("wr_pulse", wr_pulse, m_pulse);
  end

  // ---------------- stimulus helpers ----------------
  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic do_aw(input logic [31:0] a);
    bit ok = 0;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = S_AXI_AWREADY; end
    check("aw_timeout", ok, 1);
    align(); S_AXI_AWVALID = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = S_AXI_WREADY; end
    check("w_timeout", ok, 1);
    align(); S_AXI_WVALID = 0;
  endtask

  task automatic do_ar(input logic [31:0] a);
    bit ok = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = S_AXI_ARREADY; end
    check("ar_timeout", ok, 1);
    align(); S_AXI_ARVALID = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    repeat (2) align();
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk); ok = !S_AXI_BVALID && !S_AXI_RVALID;
    end
    check("idle_timeout", ok, 1);
    align();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w = 32'($urandom_range(0, 19));
    if ($urandom_range(0, 15) == 0) w = $urandom >> 2;
    return (w << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1 rst = 0;
    repeat (3) align();
    @(negedge clk);
    check("rst_reg_q", reg_q, 0);
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    align(); rst = 1;
    @(negedge clk);
    check("first_edge_awready", S_AXI_AWREADY, 0);
    check("first_edge_arready", S_AXI_ARREADY, 0);
    align();

    // Same-cycle AW/W to register 2.
    fork do_aw(32'h08); do_w(32'hDEADBEEF, 4'hF); join
    @(negedge clk); check("t1_bvalid_early", S_AXI_BVALID, 0);
    @(negedge clk);
    check("t1_bvalid", S_AXI_BVALID, 1);
    check("t1_bresp", S_AXI_BRESP, 2'b00);
    check("t1_pulse", wr_pulse, 16'h0004);
    check("t1_reg2", reg_q[95:64], 32'hDEADBEEF);
    @(negedge clk);
    check("t1_bvalid_done", S_AXI_BVALID, 0);
    check("t1_pulse_done", wr_pulse, 16'h0000);
    align();

    // W first, AW three cycles later, partial strobes.
    fork do_aw(32'h0C); do_w(32'hFFFFFFFF, 4'hF); join
    wait_idle();
    do_w(32'h11223344, 4'b0101);
    repeat (3) align();
    do_aw(32'h0C);
    @(negedge clk); check("t2_bvalid_early", S_AXI_BVALID, 0);
    @(negedge clk);
    check("t2_bvalid", S_AXI_BVALID, 1);
    check("t2_reg3", reg_q[127:96], 32'hFF22FF44);
    align(); wait_idle();

    // B back-pressure blocks new AW/W.
    S_AXI_BREADY = 0;
    fork do_aw(32'h14); do_w(32'hCAFEF00D, 4'hF); join
    align();
    S_AXI_AWADDR = 32'h18; S_AXI_AWVALID = 1;
    repeat (5) begin
      @(negedge clk);
      check("t3_bvalid_hold", S_AXI_BVALID, 1);
      check("t3_bresp_hold", S_AXI_BRESP, 2'b00);
      check("t3_awready_blocked", S_AXI_AWREADY, 0);
      check("t3_wready_blocked", S_AXI_WREADY, 0);
    end
    S_AXI_BREADY = 1;
    @(negedge clk);
    check("t3_bvalid_done", S_AXI_BVALID, 0);
    check("t3_awready_back", S_AXI_AWREADY, 1);
    align(); S_AXI_AWVALID = 0;
    do_w(32'h12345678, 4'hF);
    wait_idle();
    @(negedge clk);
    check("t3_reg5", reg_q[191:160], 32'hCAFEF00D);
    check("t3_reg6", reg_q[223:192], 32'h12345678);
    align();

    // R back-pressure.
    S_AXI_RREADY = 0;
    do_ar(32'h08);
    repeat (3) begin
      @(negedge clk);
      check("t4_rvalid_hold", S_AXI_RVALID, 1);
      check("t4_rdata_hold", S_AXI_RDATA, 32'hDEADBEEF);
      check("t4_arready_blocked", S_AXI_ARREADY, 0);
    end
    S_AXI_RREADY = 1;
    @(negedge clk);
    check("t4_rvalid_done", S_AXI_RVALID, 0);
    check("t4_arready_back", S_AXI_ARREADY, 1);
    align();

    // Read and write commit to register 4 on the same edge.
    fork do_aw(32'h10); do_w(32'hA5A5A5A5, 4'hF); join
    do_ar(32'h10);
    @(negedge clk);
    check("t5_rvalid", S_AXI_RVALID, 1);
    check("t5_rdata_old", S_AXI_RDATA, 32'h0);
    check("t5_bvalid", S_AXI_BVALID, 1);
    align(); wait_idle();
    do_ar(32'h10);
    @(negedge clk); check("t5_rdata_new", S_AXI_RDATA, 32'hA5A5A5A5);
    align(); wait_idle();

    // Out-of-range write and read.
    fork do_aw(32'h40); do_w(32'hFFFFFFFF, 4'hF); join
    @(negedge clk);
    @(negedge clk);
    check("t6_bvalid", S_AXI_BVALID, 1);
    check("t6_bresp", S_AXI_BRESP, OOR_RESP);
    check("t6_pulse", wr_pulse, 16'h0000);
    check("t6_reg0", reg_q[31:0], 32'h0);
    align(); wait_idle();
    do_ar(32'h40);
    @(negedge clk);
    check("t6_rdata", S_AXI_RDATA, 32'h0);
    check("t6_rresp", S_AXI_RRESP, OOR_RESP);
    align(); wait_idle();

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      bit aw_done, w_done, ar_done;
      @(negedge clk);
      aw_done = S_AXI_AWVALID && S_AXI_AWREADY;
      w_done  = S_AXI_WVALID && S_AXI_WREADY;
      ar_done = S_AXI_ARVALID && S_AXI_ARREADY;
      align();
      if (!S_AXI_AWVALID || aw_done) begin
        S_AXI_AWVALID = ($urandom_range(0, 2) == 0);
        S_AXI_AWADDR  = rand_addr();
      end
      if (!S_AXI_WVALID || w_done) begin
        S_AXI_WVALID = ($urandom_range(0, 2) == 0);
        S_AXI_WDATA  = $urandom;
        S_AXI_WSTRB  = 4'($urandom_range(0, 15));
      end
      if (!S_AXI_ARVALID || ar_done) begin
        S_AXI_ARVALID = ($urandom_range(0, 2) == 0);
        S_AXI_ARADDR  = rand_addr();
      end
      S_AXI_BREADY = ($urandom_range(0, 3) != 0);
      S_AXI_RREADY = ($urandom_range(0, 3) != 0);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    align();
    rst = 0; align(); rst = 1; align();

    // Reset while an address is held: nothing may commit afterwards.
    do_aw(32'h00);
    @(negedge clk); check("t7_aw_held", S_AXI_AWREADY, 0);
    align(); rst = 0;
    @(negedge clk);
    check("t7_rst_regs", reg_q, 0);
    check("t7_rst_bvalid", S_AXI_BVALID, 0);
    align(); rst = 1; align();
    do_w(32'h77777777, 4'hF);
    repeat (3) align();
    @(negedge clk);
    check("t7_no_commit", S_AXI_BVALID, 0);
    check("t7_reg0", reg_q[31:0], 32'h0);
    check("t7_no_pulse", wr_pulse, 16'h0000);
    align();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
